// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR vote monitor: FSM states, replica
// indexing and the per-bit majority function.
package tmr_pkg;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        REQ     = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    typedef logic [1:0] replica_idx_t;

    localparam int N_REPLICAS = 3;
    localparam int CONS_WIDTH = 4;

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_replica_cnt.sv
// Per-replica disagreement tracking: consecutive mismatch run length, saturating
// cumulative mismatch count and the threshold-reached flag.
module tmr_replica_cnt
    import tmr_pkg::*;
#(
    parameter int CNT_WIDTH       = 8,
    parameter int FAULT_THRESHOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic                 mismatch,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic                 thresh_hit
);

    localparam logic [CONS_WIDTH-1:0] CONS_MAX = '1;
    localparam logic [CONS_WIDTH-1:0] THRESH   = CONS_WIDTH'(FAULT_THRESHOLD);
    localparam logic [CNT_WIDTH-1:0]  ERR_MAX  = '1;

    logic [CONS_WIDTH-1:0] cons_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cons_cnt <= '0;
        end else if (clear) begin
            cons_cnt <= '0;
        end else if (valid) begin
            if (!mismatch)
                cons_cnt <= '0;
            else if (cons_cnt != CONS_MAX)
                cons_cnt <= cons_cnt + CONS_WIDTH'(1);
        end
    end

    // The cumulative count survives resync; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (valid && mismatch && err_cnt != ERR_MAX)
            err_cnt <= err_cnt + CNT_WIDTH'(1);
    end

    assign thresh_hit = (cons_cnt >= THRESH);

endmodule

// File: rtl/tmr_vote_monitor.sv
// Bitwise-majority voter over three replica words with per-replica disagreement
// tracking and a request/acknowledge resync handshake to the scrubber.
module tmr_vote_monitor
    import tmr_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int CNT_WIDTH       = 8,
    parameter int FAULT_THRESHOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     data0,
    input  logic [WIDTH-1:0]     data1,
    input  logic [WIDTH-1:0]     data2,
    output logic                 valid_out,
    output logic [WIDTH-1:0]     data_out,
    output logic [2:0]           mismatch_vec,
    output logic                 uncorrectable,
    output logic [CNT_WIDTH-1:0] err_cnt0,
    output logic [CNT_WIDTH-1:0] err_cnt1,
    output logic [CNT_WIDTH-1:0] err_cnt2,
    output logic                 resync_req,
    output logic [1:0]           fault_replica,
    input  logic                 resync_ack
);

    logic [WIDTH-1:0]      replica [N_REPLICAS];
    logic [WIDTH-1:0]      maj;
    logic [N_REPLICAS-1:0] mismatch;
    logic [N_REPLICAS-1:0] thresh_hit;
    logic [CNT_WIDTH-1:0]  err_cnt [N_REPLICAS];
    logic                  cnt_clear;
    replica_idx_t          fault_sel;
    state_t                state, next_state;

    assign replica[0] = data0;
    assign replica[1] = data1;
    assign replica[2] = data2;

    // NOTE: every always_comb output gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        maj      = '0;
        mismatch = '0;
        for (int b = 0; b < WIDTH; b++)
            maj[b] = majority(data0[b], data1[b], data2[b]);
        for (int i = 0; i < N_REPLICAS; i++)
            mismatch[i] = valid_in && (replica[i] != maj);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out     <= 1'b0;
            data_out      <= '0;
            mismatch_vec  <= '0;
            uncorrectable <= 1'b0;
        end else begin
            valid_out     <= valid_in;
            mismatch_vec  <= mismatch;
            uncorrectable <= ($countones(mismatch) >= 2);
            if (valid_in)
                data_out <= maj;
        end
    end

    for (genvar i = 0; i < N_REPLICAS; i++) begin : g_rep
        tmr_replica_cnt #(
            .CNT_WIDTH      (CNT_WIDTH),
            .FAULT_THRESHOLD(FAULT_THRESHOLD)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .valid     (valid_in),
            .mismatch  (mismatch[i]),
            .clear     (cnt_clear),
            .err_cnt   (err_cnt[i]),
            .thresh_hit(thresh_hit[i])
        );
    end

    assign err_cnt0 = err_cnt[0];
    assign err_cnt1 = err_cnt[1];
    assign err_cnt2 = err_cnt[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= MONITOR;
        else
            state <= next_state;
    end

    // Threshold events only count in MONITOR; REQ and CLEAR ignore them.
    always_comb begin
        next_state = state;
        case (state)
            MONITOR: if (|thresh_hit) next_state = REQ;
            REQ:     if (resync_ack)  next_state = CLEAR;
            CLEAR:                    next_state = MONITOR;
            default:                  next_state = MONITOR;
        endcase
    end

    always_comb begin
        if (thresh_hit[0])
            fault_sel = replica_idx_t'(0);
        else if (thresh_hit[1])
            fault_sel = replica_idx_t'(1);
        else
            fault_sel = replica_idx_t'(2);
    end

    // Captured on the MONITOR->REQ transition so it stays stable during the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fault_replica <= '0;
        else if (state == MONITOR && |thresh_hit)
            fault_replica <= fault_sel;
    end

    // Run lengths are zeroed on the acknowledging edge and held at zero through CLEAR.
    always_comb begin
        resync_req = (state == REQ);
        cnt_clear  = (state == REQ && resync_ack) || (state == CLEAR);
    end

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Self-checking bench for tmr_vote_monitor: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the voter.
module tb_tmr_vote_monitor;

    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 8;
    localparam int THR       = 4;
    localparam int CNT_MAX   = 255;
    localparam int RUN_MAX   = 15;
    localparam int S_MON = 0, S_REQ = 1, S_CLR = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 valid_in;
    logic [WIDTH-1:0]     data0, data1, data2;
    logic                 valid_out;
    logic [WIDTH-1:0]     data_out;
    logic [2:0]           mismatch_vec;
    logic                 uncorrectable;
    logic [CNT_WIDTH-1:0] err_cnt0, err_cnt1, err_cnt2;
    logic                 resync_req;
    logic [1:0]           fault_replica;
    logic                 resync_ack;

    int n_checks = 0;
    int n_fail   = 0;

    tmr_vote_monitor #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .FAULT_THRESHOLD(THR)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .data0        (data0),
        .data1        (data1),
        .data2        (data2),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .mismatch_vec (mismatch_vec),
        .uncorrectable(uncorrectable),
        .err_cnt0     (err_cnt0),
        .err_cnt1     (err_cnt1),
        .err_cnt2     (err_cnt2),
        .resync_req   (resync_req),
        .fault_replica(fault_replica),
        .resync_ack   (resync_ack)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [WIDTH-1:0] m_data;
    bit               m_vout;
    bit [2:0]         m_mvec;
    bit               m_unc;
    int               m_cum  [3];
    int               m_run  [3];
    int               m_st;
    int               m_fault;

    function automatic logic [WIDTH-1:0] vote(input logic [WIDTH-1:0] a, b, c);
        logic [WIDTH-1:0] r;
        int ones;
        r = '0;
        for (int k = 0; k < WIDTH; k++) begin
            ones = int'(a[k]) + int'(b[k]) + int'(c[k]);
            r[k] = (ones >= 2);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_data = '0; m_vout = 0; m_mvec = '0; m_unc = 0;
        m_st = S_MON; m_fault = 0;
        for (int i = 0; i < 3; i++) begin
            m_cum[i] = 0;
            m_run[i] = 0;
        end
    endtask

    task automatic model_edge(input bit v, input logic [WIDTH-1:0] a, b, c, input bit ack);
        logic [WIDTH-1:0] mj;
        logic [WIDTH-1:0] d [3];
        bit [2:0] mis;
        int nbad, ns;
        bit zero_runs;
        mj = vote(a, b, c);
        d[0] = a; d[1] = b; d[2] = c;
        nbad = 0;
        for (int i = 0; i < 3; i++) begin
            mis[i] = v && (d[i] != mj);
            nbad += int'(mis[i]);
        end
        ns = m_st;
        if (m_st == S_MON) begin
            for (int i = 2; i >= 0; i--)
                if (m_run[i] >= THR) begin
                    ns = S_REQ;
                    m_fault = i;
                end
        end else if (m_st == S_REQ) begin
            if (ack) ns = S_CLR;
        end else begin
            ns = S_MON;
        end
        zero_runs = (m_st == S_REQ && ack) || (m_st == S_CLR);
        for (int i = 0; i < 3; i++) begin
            if (mis[i] && m_cum[i] < CNT_MAX) m_cum[i]++;
            if (zero_runs)                    m_run[i] = 0;
            else if (v && !mis[i])            m_run[i] = 0;
            else if (mis[i] && m_run[i] < RUN_MAX) m_run[i]++;
        end
        m_st   = ns;
        m_vout = v;
        m_mvec = mis;
        m_unc  = (nbad >= 2);
        if (v) m_data = mj;
    endtask

    task automatic cycle(input bit v, input logic [WIDTH-1:0] a, b, c, input bit ack);
        @(negedge clk);
        valid_in = v; data0 = a; data1 = b; data2 = c; resync_ack = ack;
        @(posedge clk);
        model_edge(v, a, b, c, ack);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] nz_rand();
        logic [WIDTH-1:0] r;
        r = $urandom;
        if (r == '0) r = 1;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; valid_in = 0; data0 = '0; data1 = '0; data2 = '0; resync_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({valid_out, data_out, mismatch_vec, uncorrectable, err_cnt0, err_cnt1, err_cnt2,
             resync_req, fault_replica} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got vout=%0b data=%h mvec=%b unc=%0b cnt=%0d/%0d/%0d req=%0b fault=%0d, want all zero",
                     valid_out, data_out, mismatch_vec, uncorrectable, err_cnt0, err_cnt1, err_cnt2,
                     resync_req, fault_replica);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_agreement();
        for (int n = 0; n < 10; n++) begin
            cycle(1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0);
            n_checks++;
            if (data_out !== 32'hDEADBEEF || valid_out !== 1'b1 || mismatch_vec !== 3'b000 ||
                {err_cnt0, err_cnt1, err_cnt2} !== '0 || resync_req !== 1'b0) begin
                n_fail++;
                $display("FAIL agreement[%0d]: got data=%h vout=%0b mvec=%b cnt=%0d/%0d/%0d req=%0b, want DEADBEEF 1 000 0/0/0 0",
                         n, data_out, valid_out, mismatch_vec, err_cnt0, err_cnt1, err_cnt2, resync_req);
            end
        end
        cycle(0, $urandom, $urandom, $urandom, 0);
        n_checks++;
        if (data_out !== 32'hDEADBEEF || valid_out !== 1'b0 || mismatch_vec !== 3'b000 || uncorrectable !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got data=%h vout=%0b mvec=%b unc=%0b, want DEADBEEF 0 000 0",
                     data_out, valid_out, mismatch_vec, uncorrectable);
        end
    endtask

    task automatic test_single_upset();
        cycle(1, 32'hDEADBEEF, 32'hDEADBEEE, 32'hDEADBEEF, 0);
        n_checks++;
        if (data_out !== 32'hDEADBEEF || mismatch_vec !== 3'b010 || err_cnt1 !== 8'd1 || uncorrectable !== 1'b0) begin
            n_fail++;
            $display("FAIL single_upset: got data=%h mvec=%b cnt1=%0d unc=%0b, want DEADBEEF 010 1 0",
                     data_out, mismatch_vec, err_cnt1, uncorrectable);
        end
        cycle(1, 32'h0, 32'h0, 32'h0, 0);
    endtask

    task automatic test_persistent_fault();
        logic [WIDTH-1:0] x;
        for (int n = 0; n < THR; n++) begin
            x = $urandom;
            cycle(1, x, x, x ^ nz_rand(), 0);
        end
        n_checks++;
        if (resync_req !== 1'b0 || err_cnt2 !== 8'd4) begin
            n_fail++;
            $display("FAIL persist_pre_req: got req=%0b cnt2=%0d, want 0 4", resync_req, err_cnt2);
        end
        cycle(1, 32'h5, 32'h5, 32'h5, 0);
        n_checks++;
        if (resync_req !== 1'b1 || fault_replica !== 2'd2) begin
            n_fail++;
            $display("FAIL persist_req_rise: got req=%0b fault=%0d, want 1 2", resync_req, fault_replica);
        end
        for (int n = 0; n < 5; n++) begin
            cycle(1, 32'h5, 32'h5, 32'h5, 0);
            n_checks++;
            if (resync_req !== 1'b1 || fault_replica !== 2'd2) begin
                n_fail++;
                $display("FAIL persist_hold[%0d]: got req=%0b fault=%0d, want 1 2", n, resync_req, fault_replica);
            end
        end
        cycle(1, 32'h5, 32'h5, 32'h5, 1);
        n_checks++;
        if (resync_req !== 1'b0) begin
            n_fail++;
            $display("FAIL persist_ack_drop: got req=%0b, want 0", resync_req);
        end
        cycle(1, 32'h5, 32'h5, 32'h5, 0);
        n_checks++;
        if (resync_req !== 1'b0) begin
            n_fail++;
            $display("FAIL persist_after_clear: got req=%0b, want 0", resync_req);
        end
    endtask

    task automatic test_interleave();
        bit pattern [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
        logic [WIDTH-1:0] x;
        for (int n = 0; n < 9; n++) begin
            x = $urandom;
            cycle(1, pattern[n] ? x ^ nz_rand() : x, x, x, 0);
            n_checks++;
            if (resync_req !== 1'b0) begin
                n_fail++;
                $display("FAIL interleave_no_req[%0d]: got req=%0b, want 0", n, resync_req);
            end
        end
        n_checks++;
        if (err_cnt0 !== 8'd6) begin
            n_fail++;
            $display("FAIL interleave_cnt0: got %0d, want 6", err_cnt0);
        end
    endtask

    task automatic test_multi_disagree();
        cycle(1, 32'h1, 32'h2, 32'h0, 0);
        n_checks++;
        if (data_out !== 32'h0 || mismatch_vec !== 3'b011 || uncorrectable !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_disagree: got data=%h mvec=%b unc=%0b, want 00000000 011 1",
                     data_out, mismatch_vec, uncorrectable);
        end
        cycle(1, 32'h0, 32'h0, 32'h0, 0);
    endtask

    task automatic test_simultaneous();
        logic [WIDTH-1:0] x;
        for (int n = 0; n < THR; n++) begin
            x = $urandom;
            cycle(1, x ^ 32'h1, x ^ 32'h2, x, 0);
        end
        cycle(1, 32'h7, 32'h7, 32'h7, 0);
        n_checks++;
        if (resync_req !== 1'b1 || fault_replica !== 2'd0) begin
            n_fail++;
            $display("FAIL simul_lowest: got req=%0b fault=%0d, want 1 0", resync_req, fault_replica);
        end
        cycle(1, 32'h7, 32'h7, 32'h7, 1);
        cycle(1, 32'h7, 32'h7, 32'h7, 0);
        for (int n = 0; n < THR; n++) begin
            x = $urandom;
            cycle(1, x, x ^ nz_rand(), x, 0);
        end
        n_checks++;
        if (resync_req !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_reaccum_early: got req=%0b, want 0", resync_req);
        end
        cycle(1, 32'h7, 32'h7, 32'h7, 0);
        n_checks++;
        if (resync_req !== 1'b1 || fault_replica !== 2'd1) begin
            n_fail++;
            $display("FAIL simul_reaccum_req: got req=%0b fault=%0d, want 1 1", resync_req, fault_replica);
        end
        cycle(1, 32'h7, 32'h7, 32'h7, 1);
        cycle(1, 32'h7, 32'h7, 32'h7, 0);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] x, d [3];
        logic [63:0] got, want;
        int faulty;
        bit v, ack;
        faulty = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) faulty = $urandom_range(0, 2);
            v = ($urandom_range(0, 3) != 0);
            x = $urandom;
            for (int i = 0; i < 3; i++) begin
                d[i] = x;
                if ((i == faulty && $urandom_range(0, 9) < 8) || $urandom_range(0, 19) == 0)
                    d[i] = x ^ nz_rand();
            end
            ack = ($urandom_range(0, 3) == 0);
            cycle(v, d[0], d[1], d[2], ack);
            got  = {data_out, valid_out, mismatch_vec, uncorrectable, err_cnt0, err_cnt1, err_cnt2,
                    resync_req, fault_replica};
            want = {m_data, m_vout, m_mvec, m_unc, CNT_WIDTH'(m_cum[0]), CNT_WIDTH'(m_cum[1]),
                    CNT_WIDTH'(m_cum[2]), (m_st == S_REQ), 2'(m_fault)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h (data,vout,mvec,unc,cnt0,cnt1,cnt2,req,fault)",
                         n, got, want);
            end
        end
    endtask

    task automatic test_saturation_reset();
        logic [WIDTH-1:0] x;
        int guard;
        for (int n = 0; n < 300; n++) begin
            x = $urandom;
            cycle(1, x, x ^ nz_rand(), x, m_st == S_REQ);
        end
        n_checks++;
        if (err_cnt1 !== 8'd255 || err_cnt1 !== CNT_WIDTH'(m_cum[1])) begin
            n_fail++;
            $display("FAIL saturate_cnt1: got %0d, want 255", err_cnt1);
        end
        guard = 0;
        while (m_st != S_REQ && guard < 20) begin
            x = $urandom;
            cycle(1, x, x ^ nz_rand(), x, 0);
            guard++;
        end
        n_checks++;
        if (resync_req !== 1'b1 || m_st != S_REQ) begin
            n_fail++;
            $display("FAIL saturate_enter_req: got req=%0b after %0d cycles, want 1", resync_req, guard);
        end
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (resync_req !== 1'b0 || {err_cnt0, err_cnt1, err_cnt2} !== '0 || fault_replica !== 2'd0 ||
            data_out !== '0 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got req=%0b cnt=%0d/%0d/%0d fault=%0d data=%h vout=%0b, want all zero",
                     resync_req, err_cnt0, err_cnt1, err_cnt2, fault_replica, data_out, valid_out);
        end
        @(negedge clk);
        valid_in = 0;
        rst = 1'b0;
        for (int n = 0; n < THR; n++) begin
            x = $urandom;
            cycle(1, x, x ^ nz_rand(), x, 0);
        end
        n_checks++;
        if (resync_req !== 1'b0 || err_cnt1 !== 8'd4) begin
            n_fail++;
            $display("FAIL post_reset_runs: got req=%0b cnt1=%0d, want 0 4", resync_req, err_cnt1);
        end
        cycle(1, 32'h9, 32'h9, 32'h9, 0);
        n_checks++;
        if (resync_req !== 1'b1 || fault_replica !== 2'd1) begin
            n_fail++;
            $display("FAIL post_reset_req: got req=%0b fault=%0d, want 1 1", resync_req, fault_replica);
        end
    endtask

    initial begin
        test_reset();
        test_agreement();
        test_single_upset();
        test_persistent_fault();
        test_interleave();
        test_multi_disagree();
        test_simultaneous();
        test_random();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
